bcd_sub_serial: RTL

- Multi-digit packed-BCD subtractor, the inverse operation of the team's registered one-digit BCD adder.
- Processes one decimal digit per clock, least-significant digit first, with a ripple borrow held in a register.
- Uses a start/busy/done handshake so a control FSM or keypad/display front-end can request A − B and then display the result on 7-segment digits.
- Result is the ten's-complement difference modulo 10^DIGITS, plus a borrow flag that means A < B.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_sub.sv | 33 +++
 rtl/bcd_sub_serial.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD arithmetic blocks.
//   state_t    : control states of the serial BCD subtractor
//   BCD_W      : bits per BCD digit
//   BCD_MAX    : largest legal BCD digit value
//   BCD_BASE   : decimal radix, used to correct a negative digit difference
//   bcd_valid  : 1 when a 4-bit digit is a legal BCD value (0..9)
package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [4:0] BCD_BASE = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtractor with borrow, purely combinational.
//   x    : minuend digit (0..9)
//   y    : subtrahend digit (0..9)
//   bin  : borrow in from the next-lower digit
//   d    : difference digit (0..9)
//   bout : borrow out to the next-higher digit
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             bin,
    output logic [BCD_W-1:0] d,
    output logic             bout
);

    // 5-bit two's-complement difference; range is -10..9 for legal digits,
    // so bit 4 is the sign.
    logic [4:0] t;

    always_comb begin
        t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
        bout = t[4];
        // Adding ten only affects the low nibble result modulo 16, so the
        // correction can be done on 4 bits without carrying the sign along.
        if (t[4]) begin
            d = t[3:0] + BCD_BASE[3:0];
        end else begin
            d = t[3:0];
        end
    end

endmodule

// File: rtl/bcd_sub_serial.sv
// Serial multi-digit packed-BCD subtractor: diff = (a - b) mod 10^DIGITS.
// One digit per clock, least-significant first, borrow rippled through a
// register.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   a, b   : packed-BCD minuend / subtrahend (digit i at [4i+3:4i])
//   busy   : high while digits are being processed (CALC)
//   done   : one-cycle pulse when diff/borrow/err are valid
//   diff   : packed-BCD difference modulo 10^DIGITS
//   borrow : 1 when a < b
//   err    : 1 when an operand held a digit greater than 9
//
// Handshake: start is taken on a rising edge only while idle; a and b are
// copied on that edge and may change afterwards. busy then stays high for
// DIGITS cycles, followed by a single done cycle (busy and done are never
// high together). start during busy or done is ignored. An operand with an
// illegal digit skips the calculation and produces done on the next cycle.
// diff, borrow and err hold their values between results.
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_W*DIGITS-1:0] diff,
    output logic                  borrow,
    output logic                  err
);

    localparam int W  = BCD_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic [W-1:0]    res_sr;
    logic [W-1:0]    res_shift;
    logic            bin_q;
    logic [IW-1:0]   idx;
    logic [BCD_W-1:0] dig;
    logic            bout;
    logic            any_bad;
    logic            last;

    bcd_digit_sub u_digit (
        .x    (a_sr[BCD_W-1:0]),
        .y    (b_sr[BCD_W-1:0]),
        .bin  (bin_q),
        .d    (dig),
        .bout (bout)
    );

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(a[i*BCD_W +: BCD_W]) || !bcd_valid(b[i*BCD_W +: BCD_W])) begin
                any_bad = 1'b1;
            end
        end
    end

    assign last = (idx == IW'(DIGITS - 1));

    // New digit enters at the top so that after DIGITS shifts the first
    // (least-significant) digit has arrived at the bottom.
    assign res_shift = (res_sr >> BCD_W) | (W'(dig) << (W - BCD_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = any_bad ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bin_q  <= 1'b0;
            idx    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            err    <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            bin_q  <= 1'b0;
            idx    <= '0;
            if (any_bad) begin
                err    <= 1'b1;
                diff   <= '0;
                borrow <= 1'b0;
            end else begin
                err    <= 1'b0;
            end
        end else if (state == CALC) begin
            a_sr   <= a_sr >> BCD_W;
            b_sr   <= b_sr >> BCD_W;
            res_sr <= res_shift;
            bin_q  <= bout;
            idx    <= idx + IW'(1);
            if (last) begin
                diff   <= res_shift;
                borrow <= bout;
            end
        end
    end

endmodule
